// File: rtl/riscv_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: data width,
// register address width and the arbiter FSM encodings.
package riscv_wb_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_WAIT  = 2'd1;
  localparam logic [1:0] STATE_FORCE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_WAIT  = STATE_WAIT,
    ST_FORCE = STATE_FORCE
  } arb_state_e;

  // One-hot register mask for a destination register index.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    rd_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << rd;
  endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with per-entry valid bits and per-entry tag taps so a
// consumer can build an occupancy mask. A push while full is accepted only
// when a pop frees the slot in the same cycle.
module riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int TAG_W = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [WIDTH-1:0]              i_data,
  output logic [WIDTH-1:0]              o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [DEPTH-1:0]              o_valid,
  output logic [DEPTH-1:0][TAG_W-1:0]   o_tags
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0]            valid_q;
  logic [AW:0]                 wr_ptr_q;
  logic [AW:0]                 rd_ptr_q;
  logic [AW-1:0]               wr_idx;
  logic [AW-1:0]               rd_idx;
  logic                        do_push;
  logic                        do_pop;

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_head  = mem_q[rd_idx];
  assign o_valid = valid_q;

  // Tag taps: the top TAG_W bits of every slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_tags[i] = mem_q[i][WIDTH-1 -: TAG_W];
    end
  end

  // Pointers and valid bits; a push into the slot being popped wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr_q        <= rd_ptr_q + PTR_ONE;
        valid_q[rd_idx] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Storage needs no reset; validity is tracked by valid_q.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Register-file write-port arbiter. W-stage writes go straight through;
// long-latency unit results are queued and drained whenever W is silent.
// A head entry that waits MAX_WAIT cycles raises a one-cycle freeze request,
// and the following (bubbled) W cycle is used to drain it.
//
// state | meaning
// IDLE  | queue empty
// WAIT  | queue holds entries, wait counter running on the head
// FORCE | W is bubbled this cycle, head is written unconditionally
module riscv_wb_arbiter #(
  parameter int XLEN       = riscv_wb_arbiter_pkg::XLEN,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_wb_reg_write,
  input  logic [riscv_wb_arbiter_pkg::REG_AW-1:0] i_wb_rd,
  input  logic [XLEN-1:0]                       i_wb_data,
  input  logic                                  i_lu_valid,
  input  logic [riscv_wb_arbiter_pkg::REG_AW-1:0] i_lu_rd,
  input  logic [XLEN-1:0]                       i_lu_data,
  output logic                                  o_lu_ready,
  output logic                                  o_rf_we,
  output logic [riscv_wb_arbiter_pkg::REG_AW-1:0] o_rf_rd,
  output logic [XLEN-1:0]                       o_rf_wd,
  output logic                                  o_stall_req,
  output logic [riscv_wb_arbiter_pkg::NUM_REGS-1:0] o_pending_mask
);

  import riscv_wb_arbiter_pkg::*;

  localparam int EW = REG_AW + XLEN;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);

  arb_state_e state_q;
  logic [CW-1:0] cnt_q;

  logic [EW-1:0]                    fifo_head;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [AW:0]                      fifo_count;
  logic [FIFO_DEPTH-1:0]            fifo_valid;
  logic [FIFO_DEPTH-1:0][REG_AW-1:0] fifo_tags;

  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0]   head_data;
  logic              wb_eff;
  logic              force_cyc;
  logic              pop;
  logic              push;
  logic              lu_ready;
  logic              drained;
  logic [NUM_REGS-1:0] mask;

  assign head_rd   = fifo_head[EW-1 -: REG_AW];
  assign head_data = fifo_head[XLEN-1:0];
  assign wb_eff    = i_wb_reg_write && (i_wb_rd != '0);
  assign force_cyc = (state_q == ST_FORCE);

  // The head drains in FORCE, or in any cycle where W leaves the port free.
  assign pop      = !i_rst && !fifo_empty && (force_cyc || !wb_eff);
  assign lu_ready = !i_rst && (!fifo_full || pop);
  // rd=0 results complete the handshake but are discarded.
  assign push     = i_lu_valid && lu_ready && (i_lu_rd != '0);
  assign drained  = pop && !push && (fifo_count == FILL_ONE);

  riscv_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH),
    .TAG_W (REG_AW)
  ) u_lu_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  ({i_lu_rd, i_lu_data}),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count),
    .o_valid (fifo_valid),
    .o_tags  (fifo_tags)
  );

  // Write-port mux: FORCE head, then W, then queued head.
  always_comb begin
    o_rf_we = 1'b0;
    o_rf_rd = '0;
    o_rf_wd = '0;
    if (!i_rst) begin
      if (force_cyc && !fifo_empty) begin
        o_rf_we = 1'b1;
        o_rf_rd = head_rd;
        o_rf_wd = head_data;
      end else if (wb_eff) begin
        o_rf_we = 1'b1;
        o_rf_rd = i_wb_rd;
        o_rf_wd = i_wb_data;
      end else if (!fifo_empty) begin
        o_rf_we = 1'b1;
        o_rf_rd = head_rd;
        o_rf_wd = head_data;
      end
    end
  end

  // Pending mask over every valid queue slot, including one popping now.
  always_comb begin
    mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid[i]) begin
        mask = mask | rd_onehot(fifo_tags[i]);
      end
    end
  end

  assign o_pending_mask = i_rst ? '0 : mask;
  assign o_lu_ready     = lu_ready;
  assign o_stall_req    = !i_rst && (state_q == ST_WAIT) && (cnt_q == CNT_MAX) && !pop;

  // Starvation FSM and saturating wait counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (push) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pop) begin
            cnt_q <= '0;
            if (drained) begin
              state_q <= ST_IDLE;
            end
          end else if (cnt_q == CNT_MAX) begin
            state_q <= ST_FORCE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_FORCE: begin
          cnt_q   <= '0;
          state_q <= drained ? ST_IDLE : ST_WAIT;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter: a per-cycle vector table on a
// depth-2 instance plus ordering sequences on a depth-4 instance.
module tb_riscv_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;

  logic        lu_ready, rf_we, stall;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd, mask;
  logic        d4_lu_ready, d4_rf_we, d4_stall;
  logic [4:0]  d4_rf_rd;
  logic [31:0] d4_rf_wd, d4_mask;

  int n_tests = 0;
  int n_fail  = 0;
  bit prev_stall = 1'b0;

  riscv_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .MAX_WAIT(4)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_reg_write(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_lu_valid(lu_valid), .i_lu_rd(lu_rd), .i_lu_data(lu_data),
    .o_lu_ready(lu_ready), .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_wd(rf_wd),
    .o_stall_req(stall), .o_pending_mask(mask)
  );

  riscv_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(4), .MAX_WAIT(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_wb_reg_write(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_lu_valid(lu_valid), .i_lu_rd(lu_rd), .i_lu_data(lu_data),
    .o_lu_ready(d4_lu_ready), .o_rf_we(d4_rf_we), .o_rf_rd(d4_rf_rd), .o_rf_wd(d4_rf_wd),
    .o_stall_req(d4_stall), .o_pending_mask(d4_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          sel4;
    bit          rst;
    bit          wwe;
    logic [4:0]  wrd;
    logic [31:0] wd;
    bit          lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    bit          e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    bit          e_stall;
    bit          e_rdy;
    logic [31:0] e_mask;
  } vec_t;

  function automatic vec_t mk(string name, bit sel4, bit r, bit wwe, logic [4:0] wrd,
                              logic [31:0] wd, bit lv, logic [4:0] lrd, logic [31:0] ld,
                              bit e_we, logic [4:0] e_rd, logic [31:0] e_wd, bit e_stall,
                              bit e_rdy, logic [31:0] e_mask);
    vec_t v;
    v.name = name; v.sel4 = sel4; v.rst = r; v.wwe = wwe; v.wrd = wrd; v.wd = wd;
    v.lv = lv; v.lrd = lrd; v.ld = ld; v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd;
    v.e_stall = e_stall; v.e_rdy = e_rdy; v.e_mask = e_mask;
    return v;
  endfunction

  task automatic chk(input string nm, input string f, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h want %0h", nm, f, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    rst = v.rst; wb_we = v.wwe; wb_rd = v.wrd; wb_data = v.wd;
    lu_valid = v.lv; lu_rd = v.lrd; lu_data = v.ld;
    #2;
    if (!v.sel4) begin
      chk(v.name, "rf_we", 32'(rf_we), 32'(v.e_we));
      chk(v.name, "rf_rd", 32'(rf_rd), 32'(v.e_rd));
      chk(v.name, "rf_wd", rf_wd, v.e_wd);
      chk(v.name, "stall", 32'(stall), 32'(v.e_stall));
      chk(v.name, "lu_ready", 32'(lu_ready), 32'(v.e_rdy));
      chk(v.name, "mask", mask, v.e_mask);
    end else begin
      chk(v.name, "d4_rf_we", 32'(d4_rf_we), 32'(v.e_we));
      chk(v.name, "d4_rf_rd", 32'(d4_rf_rd), 32'(v.e_rd));
      chk(v.name, "d4_rf_wd", d4_rf_wd, v.e_wd);
      chk(v.name, "d4_stall", 32'(d4_stall), 32'(v.e_stall));
      chk(v.name, "d4_lu_ready", 32'(d4_lu_ready), 32'(v.e_rdy));
      chk(v.name, "d4_mask", d4_mask, v.e_mask);
    end
    // The cycle after a freeze request W must be a bubble.
    if (prev_stall) begin
      chk(v.name, "w_bubble_after_stall", 32'(wb_we && (wb_rd != 5'd0)), 32'd0);
    end
    prev_stall = stall || d4_stall;
    @(posedge clk);
    #1;
  endtask

  vec_t vq[$];

  initial begin
    rst = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    #1;

    //                name          s4 rst we wrd  wd        lv lrd   ld        ewe erd  ewd       st rdy mask
    vq.push_back(mk("reset",        0, 1, 0, 5'd0, 32'h0,    1, 5'd4, 32'h44,   0, 5'd0, 32'h0,    0, 0, 32'h0));
    vq.push_back(mk("push5",        0, 0, 0, 5'd0, 32'h0,    1, 5'd5, 32'hA5,   0, 5'd0, 32'h0,    0, 1, 32'h0));
    vq.push_back(mk("write5",       0, 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd5, 32'hA5,   0, 1, 32'h20));
    vq.push_back(mk("after5",       0, 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 1, 32'h0));
    vq.push_back(mk("prio_push7",   0, 0, 1, 5'd3, 32'h11,   1, 5'd7, 32'h22,   1, 5'd3, 32'h11,   0, 1, 32'h0));
    vq.push_back(mk("prio_w1",      0, 0, 1, 5'd3, 32'h11,   0, 5'd0, 32'h0,    1, 5'd3, 32'h11,   0, 1, 32'h80));
    vq.push_back(mk("prio_w2",      0, 0, 1, 5'd3, 32'h11,   0, 5'd0, 32'h0,    1, 5'd3, 32'h11,   0, 1, 32'h80));
    vq.push_back(mk("prio_w3",      0, 0, 1, 5'd3, 32'h11,   0, 5'd0, 32'h0,    1, 5'd3, 32'h11,   0, 1, 32'h80));
    vq.push_back(mk("prio_stall",   0, 0, 1, 5'd3, 32'h11,   0, 5'd0, 32'h0,    1, 5'd3, 32'h11,   1, 1, 32'h80));
    vq.push_back(mk("prio_force",   0, 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd7, 32'h22,   0, 1, 32'h80));
    vq.push_back(mk("prio_after",   0, 0, 1, 5'd3, 32'h11,   0, 5'd0, 32'h0,    1, 5'd3, 32'h11,   0, 1, 32'h0));
    vq.push_back(mk("rd0w_push9",   0, 0, 1, 5'd0, 32'h55,   1, 5'd9, 32'h99,   0, 5'd0, 32'h0,    0, 1, 32'h0));
    vq.push_back(mk("rd0w_head9",   0, 0, 1, 5'd0, 32'h55,   0, 5'd0, 32'h0,    1, 5'd9, 32'h99,   0, 1, 32'h200));
    vq.push_back(mk("lu_rd0",       0, 0, 0, 5'd0, 32'h0,    1, 5'd0, 32'h77,   0, 5'd0, 32'h0,    0, 1, 32'h0));
    vq.push_back(mk("lu_rd0_after", 0, 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 1, 32'h0));
    vq.push_back(mk("full_p10",     0, 0, 1, 5'd3, 32'h11,   1, 5'd10, 32'hA0,  1, 5'd3, 32'h11,   0, 1, 32'h0));
    vq.push_back(mk("full_p11",     0, 0, 1, 5'd3, 32'h11,   1, 5'd11, 32'hB0,  1, 5'd3, 32'h11,   0, 1, 32'h400));
    vq.push_back(mk("full_nrdy",    0, 0, 1, 5'd3, 32'h11,   1, 5'd12, 32'hC0,  1, 5'd3, 32'h11,   0, 0, 32'hC00));
    vq.push_back(mk("full_pushpop", 0, 0, 0, 5'd0, 32'h0,    1, 5'd12, 32'hC0,  1, 5'd10, 32'hA0,  0, 1, 32'hC00));
    vq.push_back(mk("full_pop11",   0, 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd11, 32'hB0,  0, 1, 32'h1800));
    vq.push_back(mk("full_pop12",   0, 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd12, 32'hC0,  0, 1, 32'h1000));
    vq.push_back(mk("full_empty",   0, 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 1, 32'h0));

    foreach (vq[i]) run_vec(vq[i]);

    // Reset mid-operation with two entries queued and the FSM waiting.
    run_vec(mk("mid_p13",   0, 0, 1, 5'd3, 32'h11, 1, 5'd13, 32'hD1, 1, 5'd3, 32'h11, 0, 1, 32'h0));
    run_vec(mk("mid_p14",   0, 0, 1, 5'd3, 32'h11, 1, 5'd14, 32'hE2, 1, 5'd3, 32'h11, 0, 1, 32'h2000));
    run_vec(mk("mid_full",  0, 0, 1, 5'd3, 32'h11, 0, 5'd0, 32'h0,   1, 5'd3, 32'h11, 0, 0, 32'h6000));
    run_vec(mk("mid_rst",   0, 1, 1, 5'd3, 32'h11, 1, 5'd15, 32'hF5, 0, 5'd0, 32'h0,  0, 0, 32'h0));
    for (int k = 0; k < 6; k++) begin
      run_vec(mk("mid_post", 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 32'h0));
    end

    // Ordering on the depth-4 instance, W idle.
    run_vec(mk("ord_p1",  1, 0, 0, 5'd0, 32'h0, 1, 5'd1, 32'h101, 0, 5'd0, 32'h0,   0, 1, 32'h0));
    run_vec(mk("ord_p2",  1, 0, 0, 5'd0, 32'h0, 1, 5'd2, 32'h102, 1, 5'd1, 32'h101, 0, 1, 32'h2));
    run_vec(mk("ord_p3",  1, 0, 0, 5'd0, 32'h0, 1, 5'd3, 32'h103, 1, 5'd2, 32'h102, 0, 1, 32'h4));
    run_vec(mk("ord_w3",  1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,   1, 5'd3, 32'h103, 0, 1, 32'h8));
    run_vec(mk("ord_end", 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   0, 1, 32'h0));

    // Ordering on the depth-4 instance with three entries queued behind W.
    run_vec(mk("ordq_p1", 1, 0, 1, 5'd4, 32'h44, 1, 5'd1, 32'h201, 1, 5'd4, 32'h44,  0, 1, 32'h0));
    run_vec(mk("ordq_p2", 1, 0, 1, 5'd4, 32'h44, 1, 5'd2, 32'h202, 1, 5'd4, 32'h44,  0, 1, 32'h2));
    run_vec(mk("ordq_p3", 1, 0, 1, 5'd4, 32'h44, 1, 5'd3, 32'h203, 1, 5'd4, 32'h44,  0, 1, 32'h6));
    run_vec(mk("ordq_w1", 1, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,   1, 5'd1, 32'h201, 0, 1, 32'hE));
    run_vec(mk("ordq_w2", 1, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,   1, 5'd2, 32'h202, 0, 1, 32'hC));
    run_vec(mk("ordq_w3", 1, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,   1, 5'd3, 32'h203, 0, 1, 32'h8));
    run_vec(mk("ordq_end",1, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   0, 1, 32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_wb_arbiter.md
# riscv_wb_arbiter

Shares the single register-file write port between the in-order pipeline writeback (W stage) and a long-latency execution unit (LU, e.g. multi-cycle divider) that completes out of band. LU results are queued in a small FIFO and written whenever W does not write. A wait counter bounds LU starvation by requesting a one-cycle pipeline freeze. The block sits between the W-stage result mux, the LU and the register file, and feeds a pending-register mask to the hazard unit.

## Interface
- `XLEN`, from `` `XLEN `` in riscv_configs: data width.
- `FIFO_DEPTH`, 2: LU result queue depth (power of two, ≥2).
- `MAX_WAIT`, 4: cycles a queued LU result may wait before a freeze is requested (≥1).

- `i_clk`  in  1  clock, all state updates on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_wb_reg_write`  in  1  W stage writes rd this cycle.
- `i_wb_rd`  in  5  W-stage destination register.
- `i_wb_data`  in  XLEN  W-stage result (the writeback mux output).
- `i_lu_valid`  in  1  LU offers a result.
- `i_lu_rd`  in  5  LU destination register.
- `i_lu_data`  in  XLEN  LU result.
- `o_lu_ready`  out  1  queue accepts the LU result this cycle.
- `o_rf_we`  out  1  register-file write enable.
- `o_rf_rd`  out  5  register-file write address.
- `o_rf_wd`  out  XLEN  register-file write data.
- `o_stall_req`  out  1  hazard unit must freeze F/D/E/M and inject a W bubble next cycle.
- `o_pending_mask`  out  32  bit r set while any queued entry targets xr.

## Operation
- The LU handshake completes when `i_lu_valid` and `o_lu_ready` are both high. The result is enqueued at the tail. `o_lu_ready` = !full and !`i_rst`.
- An entry with `i_lu_rd`=0 is accepted but never enqueued.
- A W write is effective when `i_wb_reg_write` is high and `i_wb_rd`≠0.
- Port selection is combinational, applied in this order:
  - In FORCE, the FIFO head writes.
  - Otherwise an effective W write goes through.
  - Otherwise, if the FIFO is non-empty, the head writes and is popped.
  - Otherwise `o_rf_we`=0, and `o_rf_rd`/`o_rf_wd` = 0.
- The W stage is never delayed by this block except via `o_stall_req`.
- If W writes in FORCE, W data is dropped. This is a protocol violation; the bench asserts it never occurs.
- `o_pending_mask` is the OR of one-hot(rd) over valid entries. An entry being popped this cycle still shows in the mask, because the register file write lands at the edge.
- A push and a pop in the same cycle are allowed when full: the pop frees the slot, so `o_lu_ready` = !full OR pop_this_cycle.
- FSM:
  - IDLE (FIFO empty): go to WAIT on a push.
  - WAIT: the counter increments each cycle the head is not popped and clears on every pop.
    - Go to FORCE when counter = MAX_WAIT−1 and no pop occurs this cycle; `o_stall_req`=1 combinationally in that cycle.
    - Go to IDLE when the FIFO becomes empty.
  - FORCE: one cycle. The head writes and pops and the counter clears. Next state is WAIT if entries remain, else IDLE.
- The counter saturates at MAX_WAIT−1.
- Reset clears the FIFO pointers, counter and state (IDLE) regardless of the current state. In-flight LU results are lost; the LU is reset by the same `i_rst`.

## Timing
- Reset values: `o_rf_we`=0, `o_rf_rd`=0, `o_rf_wd`=0, `o_stall_req`=0, `o_pending_mask`=0, `o_lu_ready`=0 while `i_rst`=1. After reset `o_lu_ready`=1.
- LU to register file: minimum 1 cycle. Accepted at edge n, it is written in cycle n+1 if W is idle.
- Worst-case LU wait from reaching the head to write: MAX_WAIT+1 cycles.
- `o_stall_req` is high exactly one cycle per FORCE event. The hazard unit bubbles W in the following cycle.
- The write port path is combinational (no added latency to W). Mask, state, counter and FIFO are registered.

## Structure
- Shared package or riscv_configs: `XLEN`, the register-address width (5) and the FSM state encodings (IDLE/WAIT/FORCE as localparams).
- One sub-module, `riscv_sync_fifo`: synchronous FIFO (push/pop/full/empty, head data, per-entry valid for the mask), parameterized on width and depth. It is reusable by the LU and load queues.

## Test plan
- Basic flow: reset, W idle, LU pushes rd=5, data 0xA5 at edge 0 -> cycle 1: `o_rf_we`=1, rd=5, wd=0xA5; `o_pending_mask`[5]=1 in cycle 1 and 0 in cycle 2.
- Priority: W writes rd=3/0x11 continuously, LU pushes rd=7/0x22 -> W wins each cycle. `o_stall_req` is high exactly MAX_WAIT cycles after the push. The next cycle (W bubble) writes rd=7, 0x22.
- Full queue: stall drain with W writes, push 2 entries -> `o_lu_ready`=0. Then idle W with `i_lu_valid` held -> pop and push in the same cycle, and ready stays 1.
- rd=0: W rd=0 with LU head rd=9 -> head written the same cycle. An LU push with rd=0 -> accepted, no write, mask unchanged.
- Reset mid-operation: 2 entries queued with the state in WAIT, assert `i_rst` for 1 cycle -> all outputs at reset values, state IDLE, no later write of the old entries.
- Ordering: push rd=1, 2, 3 back-to-back with FIFO_DEPTH=4 and W idle -> writes in order 1, 2, 3 on consecutive cycles.
